// File: rtl/axi_lite_pkg.sv
// Shared constants and FSM encoding for the AXI4-Lite initiator.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_B,
    ST_RD_A,
    ST_RD_R,
    ST_RSP
  } state_e;

endpackage

// File: rtl/axi_lite_initiator_wr_track.sv
// Tracks completion of the independent AW and W handshakes of one write.
module axi_lite_initiator_wr_track (
  input  logic aclk,
  input  logic areset,
  input  logic active,
  input  logic aw_hs,
  input  logic w_hs,
  output logic aw_done,
  output logic w_done,
  output logic both_done
);

  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  // Flags self-clear whenever the FSM is outside the write address/data phase.
  always_comb begin
    aw_done_d = active & (aw_done_q | aw_hs);
    w_done_d  = active & (w_done_q | w_hs);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign aw_done   = aw_done_q;
  assign w_done    = w_done_q;
  assign both_done = aw_done_d & w_done_d;

endmodule

// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI4-Lite master bridging a valid/ready request port.
// Optional channel watchdog enabled by AXI_LITE_INITIATOR_TIMEOUT_EN.
module axi_lite_initiator
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 1024,
`endif
  parameter int DATA_WIDTH  = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic                    wr_active, aw_hs, w_hs, aw_done, w_done, both_done;
  logic                    timeout;

  assign wr_active = (state_q == ST_WR);
  assign aw_hs     = m_axi_awvalid & m_axi_awready;
  assign w_hs      = m_axi_wvalid & m_axi_wready;

  axi_lite_initiator_wr_track u_wr_track (
    .aclk      (aclk),
    .areset    (areset),
    .active    (wr_active),
    .aw_hs     (aw_hs),
    .w_hs      (w_hs),
    .aw_done   (aw_done),
    .w_done    (w_done),
    .both_done (both_done)
  );

`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;

  assign waiting = state_q inside {ST_WR, ST_WR_B, ST_RD_A, ST_RD_R};
  assign timeout = waiting && (cnt_q == CNT_LAST);

  // Restarts from zero on every state change so each channel gets a full budget.
  always_comb begin
    cnt_d = '0;
    if (waiting && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (areset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        wstrb_d = req_wstrb;
        state_d = req_write ? ST_WR : ST_RD_A;
      end
      ST_WR:   if (both_done) state_d = ST_WR_B;
      ST_WR_B: if (m_axi_bvalid) begin
        resp_d  = m_axi_bresp;
        rdata_d = '0;
        state_d = ST_RSP;
      end
      ST_RD_A: if (m_axi_arready) state_d = ST_RD_R;
      ST_RD_R: if (m_axi_rvalid) begin
        rdata_d = m_axi_rdata;
        resp_d  = m_axi_rresp;
        state_d = ST_RSP;
      end
      ST_RSP:  if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over any handshake landing in the same cycle.
    if (timeout) begin
      state_d = ST_RSP;
      resp_d  = RESP_SLVERR;
      rdata_d = DATA_WIDTH'(TIMEOUT_RDATA);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    req_ready     = (state_q == ST_IDLE);
    m_axi_awvalid = wr_active & ~aw_done;
    m_axi_wvalid  = wr_active & ~w_done;
    m_axi_bready  = (state_q == ST_WR_B);
    m_axi_arvalid = (state_q == ST_RD_A);
    m_axi_rready  = (state_q == ST_RD_R);
    rsp_valid     = (state_q == ST_RSP);
  end

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign rsp_rdata    = rdata_q;
  assign rsp_resp     = resp_q;

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Randomized self-checking bench for axi_lite_initiator with a delay-programmable AXI-Lite slave.
module tb_axi_lite_initiator;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
  logic        m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
  logic [31:0] m_axi_rdata = '0;

  always #5 aclk = ~aclk;

  axi_lite_initiator #(
    .ADDR_WIDTH (32),
`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
    .TIMEOUT_CYC(16),
`endif
    .DATA_WIDTH (32)
  ) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int checks = 0, errors = 0;

  // Slave knobs: cycles from valid seen to ready (or from owed to valid).
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit          ar_never = 1'b0;
  logic [1:0]  b_resp_c = 2'b00, r_resp_c = 2'b00;
  logic [31:0] r_data_c = '0;

  // Monitor state, updated at posedge from pre-edge values.
  int          cyc = 0, acc_cyc = 0, rsp_rise = 0;
  int          aw_got = 0, w_got = 0, b_got = 0, ar_got = 0, r_got = 0;
  int          rsp_cnt = 0, rsp_seen = 0, rdy_bad = 0, aw_only = 0, ar_cyc = 0, viol = 0;
  bit          rdy_at_consume = 1'b0, allow_drop = 1'b0;
  logic [31:0] mon_awaddr = '0, mon_wdata = '0, mon_araddr = '0, g_rdata = '0;
  logic [3:0]  mon_wstrb = '0;
  logic [1:0]  g_resp = '0;
  bit          rsp_prev = 1'b0, aw_h = 1'b0, w_h = 1'b0, ar_h = 1'b0, rs_h = 1'b0;
  logic [31:0] aw_hv, w_hv, ar_hv;
  logic [33:0] rs_hv;

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  always @(posedge aclk) begin
    if (!areset) begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (m_axi_awvalid && m_axi_awready) begin aw_got++; mon_awaddr = m_axi_awaddr; end
      if (m_axi_wvalid && m_axi_wready) begin w_got++; mon_wdata = m_axi_wdata; mon_wstrb = m_axi_wstrb; end
      if (m_axi_bvalid && m_axi_bready) b_got++;
      if (m_axi_arvalid && m_axi_arready) begin ar_got++; mon_araddr = m_axi_araddr; end
      if (m_axi_rvalid && m_axi_rready) r_got++;
      if (rsp_valid && !rsp_prev) rsp_rise = cyc;
      if (rsp_valid) rsp_seen++;
      if (rsp_valid && req_ready) rdy_bad++;
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++; g_rdata = rsp_rdata; g_resp = rsp_resp; rdy_at_consume = req_ready;
      end
      if (m_axi_awvalid && !m_axi_wvalid) aw_only++;
      if (m_axi_arvalid) ar_cyc++;
      // A valid left waiting must still be up next cycle with the same payload.
      if (!allow_drop) begin
        if (aw_h && (!m_axi_awvalid || m_axi_awaddr !== aw_hv)) viol++;
        if (w_h && (!m_axi_wvalid || m_axi_wdata !== w_hv)) viol++;
        if (ar_h && (!m_axi_arvalid || m_axi_araddr !== ar_hv)) viol++;
      end
      if (rs_h && (!rsp_valid || {rsp_rdata, rsp_resp} !== rs_hv)) viol++;
      aw_h = m_axi_awvalid && !m_axi_awready; aw_hv = m_axi_awaddr;
      w_h  = m_axi_wvalid && !m_axi_wready;   w_hv  = m_axi_wdata;
      ar_h = m_axi_arvalid && !m_axi_arready; ar_hv = m_axi_araddr;
      rs_h = rsp_valid && !rsp_ready;         rs_hv = {rsp_rdata, rsp_resp};
      rsp_prev = rsp_valid;
    end else begin
      aw_h = 1'b0; w_h = 1'b0; ar_h = 1'b0; rs_h = 1'b0; rsp_prev = 1'b0;
    end
    cyc++;
  end

  // AXI-Lite slave, driven on the falling edge.
  int aw_w = 0, w_w = 0, ar_w = 0, b_w = 0, r_w = 0, b_iss = 0, r_iss = 0;
  always @(negedge aclk) begin
    if (areset) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0; m_axi_bvalid = 0; m_axi_rvalid = 0;
      aw_w = 0; w_w = 0; ar_w = 0; b_w = 0; r_w = 0;
      b_iss = imin(aw_got, w_got); r_iss = ar_got;
    end else begin
      if (m_axi_awready) m_axi_awready = 0;
      else if (m_axi_awvalid) begin if (aw_w >= aw_dly) begin m_axi_awready = 1; aw_w = 0; end else aw_w++; end
      if (m_axi_wready) m_axi_wready = 0;
      else if (m_axi_wvalid) begin if (w_w >= w_dly) begin m_axi_wready = 1; w_w = 0; end else w_w++; end
      if (m_axi_arready) m_axi_arready = 0;
      else if (m_axi_arvalid && !ar_never) begin if (ar_w >= ar_dly) begin m_axi_arready = 1; ar_w = 0; end else ar_w++; end
      if (m_axi_bvalid) begin if (b_got == b_iss) m_axi_bvalid = 0; end
      else if (imin(aw_got, w_got) > b_iss) begin
        if (b_w >= b_dly) begin m_axi_bvalid = 1; m_axi_bresp = b_resp_c; b_iss++; b_w = 0; end else b_w++;
      end
      if (m_axi_rvalid) begin if (r_got == r_iss) m_axi_rvalid = 0; end
      else if (ar_got > r_iss) begin
        if (r_w >= r_dly) begin
          m_axi_rvalid = 1; m_axi_rdata = r_data_c; m_axi_rresp = r_resp_c; r_iss++; r_w = 0;
        end else r_w++;
      end
    end
  end

  int lat = 0;

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int hold);
    int n, c;
    n = rsp_cnt;
    @(negedge aclk);
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    rsp_ready = (hold == 0);
    c = 0;
    while (!req_ready && c < 100) begin @(negedge aclk); c++; end
    @(negedge aclk);
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
    c = 0;
    while (!rsp_valid && c < 200) begin @(negedge aclk); c++; end
    repeat (hold) @(negedge aclk);
    rsp_ready = 1;
    c = 0;
    while (rsp_cnt == n && c < 50) begin @(negedge aclk); c++; end
    checks++;
    if (rsp_cnt != n + 1) begin
      errors++; $display("FAIL txn_done got %0d responses exp 1", rsp_cnt - n);
    end
    lat = rsp_rise - acc_cyc;
  endtask

  task automatic test_reset();
    areset = 1; req_valid = 0; rsp_ready = 0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL rst_valids got %b exp 000000",
        {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid});
    end
    checks++;
    if ({rsp_rdata, rsp_resp} !== 34'd0) begin
      errors++; $display("FAIL rst_rsp got %h/%b exp 0/00", rsp_rdata, rsp_resp);
    end
    checks++;
    if ({m_axi_awprot, m_axi_arprot} !== 6'b0) begin
      errors++; $display("FAIL prot got %b exp 000000", {m_axi_awprot, m_axi_arprot});
    end
    areset = 0;
    @(negedge aclk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_zero_wait_write();
    int a0, w0, o0;
    aw_dly = 0; w_dly = 0; b_dly = 0; b_resp_c = 2'b00;
    a0 = aw_got; w0 = w_got; o0 = aw_only;
    do_txn(1, 32'h10, 32'hA5A5_1234, 4'hF, 0);
    checks++; if (lat != 3) begin errors++; $display("FAIL zw_latency got %0d exp 3", lat); end
    checks++; if (g_resp !== 2'b00) begin errors++; $display("FAIL zw_resp got %b exp 00", g_resp); end
    checks++; if (g_rdata !== 32'h0) begin errors++; $display("FAIL zw_rdata got %h exp 0", g_rdata); end
    checks++;
    if ({mon_awaddr, mon_wdata, mon_wstrb} !== {32'h10, 32'hA5A5_1234, 4'hF}) begin
      errors++; $display("FAIL zw_payload got %h %h %h exp 10 a5a51234 f", mon_awaddr, mon_wdata, mon_wstrb);
    end
    checks++;
    if (aw_got - a0 != 1 || w_got - w0 != 1 || aw_only != o0) begin
      errors++; $display("FAIL zw_same_cycle got aw%0d w%0d skew%0d exp 1 1 0", aw_got - a0, w_got - w0, aw_only - o0);
    end
  endtask

  task automatic test_skewed_write();
    int o0, b0, v0;
    logic [31:0] a;
    aw_dly = 5; w_dly = 0; b_dly = 0; b_resp_c = 2'b00;
    a = $urandom & 32'hFFFF_FFFC;
    o0 = aw_only; b0 = b_got; v0 = viol;
    do_txn(1, a, $urandom, 4'h3, 0);
    checks++; if (aw_only - o0 != 5) begin errors++; $display("FAIL skew_aw_alone got %0d exp 5", aw_only - o0); end
    checks++; if (b_got - b0 != 1) begin errors++; $display("FAIL skew_b_count got %0d exp 1", b_got - b0); end
    checks++; if (lat != 8) begin errors++; $display("FAIL skew_latency got %0d exp 8", lat); end
    checks++; if (mon_awaddr !== a) begin errors++; $display("FAIL skew_awaddr got %h exp %h", mon_awaddr, a); end
    checks++; if (viol != v0) begin errors++; $display("FAIL skew_stable got %0d exp 0", viol - v0); end
    aw_dly = 0;
  endtask

  task automatic test_read_backpressure();
    int v0, r0;
    ar_dly = 0; r_dly = 0; r_data_c = 32'hCAFE_F00D; r_resp_c = 2'b00;
    v0 = viol; r0 = rdy_bad;
    do_txn(0, 32'h40, 32'h0, 4'h0, 4);
    checks++; if (g_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL bp_rdata got %h exp cafef00d", g_rdata); end
    checks++; if (g_resp !== 2'b00) begin errors++; $display("FAIL bp_resp got %b exp 00", g_resp); end
    checks++; if (lat != 3) begin errors++; $display("FAIL bp_latency got %0d exp 3", lat); end
    checks++; if (viol != v0) begin errors++; $display("FAIL bp_rsp_stable got %0d exp 0", viol - v0); end
    checks++;
    if (rdy_bad != r0 || rdy_at_consume !== 1'b0) begin
      errors++; $display("FAIL bp_req_ready_low got %0d/%b exp 0/0", rdy_bad - r0, rdy_at_consume);
    end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_req_ready_after got %b exp 1", req_ready); end
    checks++; if (mon_araddr !== 32'h40) begin errors++; $display("FAIL bp_araddr got %h exp 40", mon_araddr); end
  endtask

  task automatic test_error_passthrough();
    logic [31:0] d;
    d = $urandom;
    r_data_c = d; r_resp_c = 2'b11;
    do_txn(0, 32'h80, 32'h0, 4'h0, 0);
    checks++; if (g_resp !== 2'b11) begin errors++; $display("FAIL err_rresp got %b exp 11", g_resp); end
    checks++; if (g_rdata !== d) begin errors++; $display("FAIL err_rdata got %h exp %h", g_rdata, d); end
    b_resp_c = 2'b10;
    do_txn(1, 32'h84, $urandom, 4'h1, 0);
    checks++; if (g_resp !== 2'b10) begin errors++; $display("FAIL err_bresp got %b exp 10", g_resp); end
    checks++; if (g_rdata !== 32'h0) begin errors++; $display("FAIL err_wr_rdata got %h exp 0", g_rdata); end
    b_resp_c = 2'b00; r_resp_c = 2'b00;
  endtask

  task automatic test_random();
    bit          wr;
    logic [31:0] a, wd, exp_d;
    logic [3:0]  st;
    logic [1:0]  exp_r;
    int          exp_lat, v0;
    v0 = viol;
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom);
      a = $urandom; wd = $urandom; st = 4'($urandom);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      b_resp_c = 2'($urandom); r_resp_c = 2'($urandom); r_data_c = $urandom;
      // Response is the B code for writes, the R beat for reads; latency grows by the slave stalls.
      exp_d   = wr ? 32'h0 : r_data_c;
      exp_r   = wr ? b_resp_c : r_resp_c;
      exp_lat = wr ? 3 + imax(aw_dly, w_dly) + b_dly : 3 + ar_dly + r_dly;
      do_txn(wr, a, wd, st, $urandom_range(0, 2));
      checks++;
      if ({g_rdata, g_resp} !== {exp_d, exp_r}) begin
        errors++; $display("FAIL rnd%0d_rsp got %h/%b exp %h/%b", i, g_rdata, g_resp, exp_d, exp_r);
      end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, exp_lat); end
      checks++;
      if (wr ? ({mon_awaddr, mon_wdata, mon_wstrb} !== {a, wd, st}) : (mon_araddr !== a)) begin
        errors++; $display("FAIL rnd%0d_payload got %h exp %h", i, wr ? mon_awaddr : mon_araddr, a);
      end
    end
    checks++; if (viol != v0) begin errors++; $display("FAIL rnd_stable got %0d exp 0", viol - v0); end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; b_resp_c = 0; r_resp_c = 0;
  endtask

  task automatic test_reset_mid_read();
    int c, s0;
    ar_dly = 0; r_dly = 8; r_data_c = 32'h1234_5678;
    @(negedge aclk);
    req_valid = 1; req_write = 0; req_addr = 32'hC0;
    c = 0;
    while (!req_ready && c < 20) begin @(negedge aclk); c++; end
    @(negedge aclk);
    req_valid = 0;
    c = 0;
    while (!m_axi_rready && c < 20) begin @(negedge aclk); c++; end
    checks++; if (m_axi_rready !== 1'b1) begin errors++; $display("FAIL mid_reach_rd_r got %b exp 1", m_axi_rready); end
    areset = 1;
    @(negedge aclk);
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid, req_ready} !== 7'b0000001) begin
      errors++; $display("FAIL mid_rst_outputs got %b exp 0000001",
        {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid, req_ready});
    end
    areset = 0; rsp_ready = 1; s0 = rsp_seen;
    repeat (15) @(negedge aclk);
    checks++; if (rsp_seen != s0) begin errors++; $display("FAIL mid_no_rsp got %0d exp 0", rsp_seen - s0); end
    r_dly = 0; r_data_c = 32'h0BAD_F00D;
    do_txn(0, 32'hC4, 32'h0, 4'h0, 0);
    checks++; if (g_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL mid_recover got %h exp 0badf00d", g_rdata); end
  endtask

`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
  task automatic test_timeout();
    int a0, g0;
    ar_never = 1; allow_drop = 1;
    a0 = ar_cyc; g0 = ar_got;
    do_txn(0, 32'h100, 32'h0, 4'h0, 0);
    checks++; if (ar_cyc - a0 != 16) begin errors++; $display("FAIL to_arvalid_cycles got %0d exp 16", ar_cyc - a0); end
    checks++; if (ar_got != g0) begin errors++; $display("FAIL to_no_ar got %0d exp 0", ar_got - g0); end
    checks++; if (g_resp !== 2'b10) begin errors++; $display("FAIL to_resp got %b exp 10", g_resp); end
    checks++; if (g_rdata !== 32'hDEAD_0000) begin errors++; $display("FAIL to_rdata got %h exp dead0000", g_rdata); end
    checks++; if (lat != 17) begin errors++; $display("FAIL to_latency got %0d exp 17", lat); end
    ar_never = 0;
    @(negedge aclk);
    allow_drop = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait_write();
    test_skewed_write();
    test_read_backpressure();
    test_error_passthrough();
    test_random();
    test_reset_mid_read();
`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
